chime_alarm_ctrl: RTL and testbench

Parametrised buzzer controller for the digital-clock top level. Watches the BCD time-of-day, sounds a configurable hourly pre-warning/top-of-hour chime, and runs N independent alarms with timeout and acknowledge. All tones are generated internally from `clk`; no external tone clocks. Sits between the time counter and the buzzer pin.

---
 rtl/chime_alarm_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_chime_alarm_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chime_alarm_ctrl.sv
// chime_alarm_ctrl: buzzer controller for the digital clock. Sounds a
// pre-warning beep sequence before each hour, a top-of-hour chime, and
// N_ALARMS independent alarms with timeout and acknowledge. All tones are
// divided down from clk.
//
// Optional feature macro: CHIME_SNOOZE_EN (adds the SNOOZE state/counter).
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   sec_tick           one-cycle pulse, time inputs already show new second
//   Hour_First..Second_Second  BCD time-of-day digits
//   alarm_time         per channel {HF,HS,MF,MS}, channel i at [16i+15:16i]
//   alarm_en           per-channel alarm enable
//   chime_en           hourly chime enable
//   ack                stops an active (or snoozed) alarm
//   snooze             snooze request (only with CHIME_SNOOZE_EN)
//   buzzerOutput       registered tone output
//   busy               high whenever the controller is not idle
//   alarm_hit          channels that fired in the current alarm episode
module chime_alarm_ctrl #(
  parameter int unsigned HALF_PRE    = 4,
  parameter int unsigned HALF_TOP    = 2,
  parameter int unsigned N_ALARMS    = 2,
  parameter int unsigned PRE_BEEPS   = 5,
  parameter int unsigned ALARM_SECS  = 60,
  parameter int unsigned SNOOZE_SECS = 120
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sec_tick,
  input  logic [3:0]              Hour_First,
  input  logic [3:0]              Hour_Second,
  input  logic [3:0]              Minute_First,
  input  logic [3:0]              Minute_Second,
  input  logic [3:0]              Second_First,
  input  logic [3:0]              Second_Second,
  input  logic [16*N_ALARMS-1:0]  alarm_time,
  input  logic [N_ALARMS-1:0]     alarm_en,
  input  logic                    chime_en,
  input  logic                    ack,
  input  logic                    snooze,
  output logic                    buzzerOutput,
  output logic                    busy,
  output logic [N_ALARMS-1:0]     alarm_hit
);

  localparam int unsigned CW       = 8;
  localparam int unsigned HALF_MAX = (HALF_PRE > HALF_TOP) ? HALF_PRE : HALF_TOP;
  localparam int unsigned DW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

`ifdef CHIME_SNOOZE_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_TOP    = 3'd2,
    S_ALARM  = 3'd3,
    S_SNOOZE = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_TOP   = 2'd2,
    S_ALARM = 2'd3
  } state_t;
`endif

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [N_ALARMS-1:0] hit_d;
  logic [N_ALARMS-1:0] match_c;
  logic [DW-1:0]       div, div_d, half_m1_c;
  logic                tone, tone_d;
  logic                phase, phase_d;
  logic                buzz_d;
  logic                top_sec_c, pre_sec_c, ack_c, tone_state_c;

  // Alarm match: enabled channel, HH:MM equal, seconds exactly 00.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(N_ALARMS); i++) begin
      match_c[i] = alarm_en[i] &&
                   (alarm_time[16*i +: 16] ==
                    {Hour_First, Hour_Second, Minute_First, Minute_Second});
    end
    if (!((Second_First == 4'd0) && (Second_Second == 4'd0))) begin
      match_c = '0;
    end
  end

  assign top_sec_c = (Minute_First == 4'd0) && (Minute_Second == 4'd0) &&
                     (Second_First == 4'd0) && (Second_Second == 4'd0);

  // Pre-beep seconds are 60-2k for k = 1..PRE_BEEPS within minute 59.
  always_comb begin
    pre_sec_c = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if ((k <= int'(PRE_BEEPS)) &&
          (Second_First  == 4'((60 - 2*k) / 10)) &&
          (Second_Second == 4'((60 - 2*k) % 10))) begin
        pre_sec_c = 1'b1;
      end
    end
    pre_sec_c = pre_sec_c && (Minute_First == 4'd5) && (Minute_Second == 4'd9);
  end

`ifdef CHIME_SNOOZE_EN
  assign ack_c = ack && ((state == S_ALARM) || (state == S_SNOOZE));
`else
  assign ack_c = ack && (state == S_ALARM);
  logic unused_snooze;
  assign unused_snooze = snooze ^ (SNOOZE_SECS == 0);
`endif

  // Next state, second counter and hit mask.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hit_d   = alarm_hit;
    if (ack_c) begin
      state_d = S_IDLE;
    end else if (sec_tick && (|match_c)) begin
      state_d = S_ALARM;
      hit_d   = alarm_hit | match_c;
      cnt_d   = CW'(ALARM_SECS);
`ifdef CHIME_SNOOZE_EN
    end else if (snooze && (state == S_ALARM)) begin
      state_d = S_SNOOZE;
      cnt_d   = CW'(SNOOZE_SECS);
`endif
    end else if (sec_tick) begin
      case (state)
        S_ALARM: begin
          if (cnt < CW'(2)) state_d = S_IDLE;
          else              cnt_d   = cnt - CW'(1);
        end
`ifdef CHIME_SNOOZE_EN
        S_SNOOZE: begin
          if (cnt < CW'(2)) begin
            state_d = S_ALARM;
            cnt_d   = CW'(ALARM_SECS);
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
`endif
        default: begin
          if (chime_en && top_sec_c)      state_d = S_TOP;
          else if (chime_en && pre_sec_c) state_d = S_PRE;
          else                            state_d = S_IDLE;
        end
      endcase
    end
    // Leaving an episode (or staying idle) clears the episode record.
    if (state_d == S_IDLE) begin
      hit_d = '0;
      cnt_d = '0;
    end
  end

  // Tone divider; restarts from 0 on any state change so the first rising
  // edge always comes a full half-period after entry.
  always_comb begin
    half_m1_c    = (state == S_PRE) ? DW'(HALF_PRE - 1) : DW'(HALF_TOP - 1);
    tone_state_c = (state == S_PRE) || (state == S_TOP) || (state == S_ALARM);
    div_d        = '0;
    tone_d       = 1'b0;
    phase_d      = 1'b0;
    if ((state_d == state) && tone_state_c) begin
      // phase = 1 marks odd seconds of an alarm episode (silent).
      phase_d = phase ^ (sec_tick && (state == S_ALARM));
      if (div == half_m1_c) begin
        div_d  = '0;
        tone_d = ~tone;
      end else begin
        div_d  = div + DW'(1);
        tone_d = tone;
      end
    end
    buzz_d = tone_d && ((state_d == S_PRE) || (state_d == S_TOP) ||
                        ((state_d == S_ALARM) && !phase_d));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      alarm_hit    <= '0;
      div          <= '0;
      tone         <= 1'b0;
      phase        <= 1'b0;
      buzzerOutput <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      alarm_hit    <= hit_d;
      div          <= div_d;
      tone         <= tone_d;
      phase        <= phase_d;
      buzzerOutput <= buzz_d;
      busy         <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_chime_alarm_ctrl.sv
// Self-checking bench for chime_alarm_ctrl (default build, snooze absent).
// A behavioural model tracks the mode, cycles since mode entry and seconds
// into the alarm episode, and predicts the outputs after every clock edge.
module tb_chime_alarm_ctrl;

  localparam int unsigned HALF_PRE    = 4;
  localparam int unsigned HALF_TOP    = 2;
  localparam int unsigned N_ALARMS    = 2;
  localparam int unsigned PRE_BEEPS   = 5;
  localparam int unsigned ALARM_SECS  = 60;
  localparam int unsigned SNOOZE_SECS = 120;

  logic        clk = 1'b0;
  logic        rst, sec_tick, chime_en, ack, snooze;
  logic [3:0]  Hour_First, Hour_Second, Minute_First, Minute_Second;
  logic [3:0]  Second_First, Second_Second;
  logic [31:0] alarm_time;
  logic [1:0]  alarm_en;
  logic        buzzerOutput, busy;
  logic [1:0]  alarm_hit;

  always #5 clk = ~clk;

  chime_alarm_ctrl #(
    .HALF_PRE(HALF_PRE), .HALF_TOP(HALF_TOP), .N_ALARMS(N_ALARMS),
    .PRE_BEEPS(PRE_BEEPS), .ALARM_SECS(ALARM_SECS), .SNOOZE_SECS(SNOOZE_SECS)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .Hour_First(Hour_First), .Hour_Second(Hour_Second),
    .Minute_First(Minute_First), .Minute_Second(Minute_Second),
    .Second_First(Second_First), .Second_Second(Second_Second),
    .alarm_time(alarm_time), .alarm_en(alarm_en), .chime_en(chime_en),
    .ack(ack), .snooze(snooze),
    .buzzerOutput(buzzerOutput), .busy(busy), .alarm_hit(alarm_hit)
  );

  int checks = 0;
  int errors = 0;
  int tod;

  typedef enum int {M_IDLE, M_PRE, M_TOP, M_ALARM} mode_t;
  mode_t      m_mode;
  int         m_age;         // clock edges since the current mode was entered
  int         m_sec;         // seconds elapsed in the current alarm episode
  int         m_since_load;  // ticks since the alarm duration was (re)loaded
  logic [1:0] m_hit;

  function automatic int dig_val(logic [3:0] a, logic [3:0] b);
    return (a < 4'd10 && b < 4'd10) ? int'(a) * 10 + int'(b) : -1;
  endfunction

  function automatic logic [15:0] bcd16(int hh, int mm);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic drive_time(int t);
    int hh, mm, ss;
    hh = t / 3600; mm = (t / 60) % 60; ss = t % 60;
    Hour_First    = 4'(hh / 10); Hour_Second   = 4'(hh % 10);
    Minute_First  = 4'(mm / 10); Minute_Second = 4'(mm % 10);
    Second_First  = 4'(ss / 10); Second_Second = 4'(ss % 10);
  endtask

  // Reference model: apply the priority rules to the inputs seen at the edge.
  task automatic model_edge();
    mode_t      nxt;
    logic [1:0] m;
    int         mm, ss;
    bit         top, pre;
    if (rst) begin
      m_mode = M_IDLE; m_age = 0; m_sec = 0; m_since_load = 0; m_hit = 2'b00;
      return;
    end
    mm  = dig_val(Minute_First, Minute_Second);
    ss  = dig_val(Second_First, Second_Second);
    top = (mm == 0) && (ss == 0);
    pre = (mm == 59) && (ss >= 60 - 2 * int'(PRE_BEEPS)) && (ss <= 58) && (ss % 2 == 0);
    for (int i = 0; i < 2; i++) begin
      m[i] = alarm_en[i] && (ss == 0) &&
             (alarm_time[16*i +: 16] == {Hour_First, Hour_Second, Minute_First, Minute_Second});
    end
    nxt = m_mode;
    if (ack && m_mode == M_ALARM) begin
      nxt = M_IDLE;
    end else if (sec_tick && m != 2'b00) begin
      nxt = M_ALARM;
      m_hit = m_hit | m;
      m_since_load = 0;
    end else if (sec_tick) begin
      if (m_mode == M_ALARM) begin
        if (m_since_load + 1 >= int'(ALARM_SECS)) nxt = M_IDLE;
        else m_since_load++;
      end else if (chime_en && top) nxt = M_TOP;
      else if (chime_en && pre)     nxt = M_PRE;
      else                          nxt = M_IDLE;
    end
    if (nxt != m_mode) begin
      m_age = 0; m_sec = 0;
    end else begin
      m_age++;
      if (m_mode == M_ALARM && sec_tick) m_sec++;
    end
    if (nxt == M_IDLE) m_hit = 2'b00;
    m_mode = nxt;
  endtask

  function automatic logic exp_buzz();
    case (m_mode)
      M_PRE:   return ((m_age / int'(HALF_PRE)) % 2) == 1;
      M_TOP:   return ((m_age / int'(HALF_TOP)) % 2) == 1;
      M_ALARM: return (m_sec % 2 == 0) && (((m_age / int'(HALF_TOP)) % 2) == 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_bit(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_vec(string tag, logic [1:0] obs, logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // One clock: update model on the edge, compare outputs 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk_bit("buzzer", buzzerOutput, exp_buzz());
    chk_bit("busy", busy, m_mode != M_IDLE);
    chk_vec("alarm_hit", alarm_hit, m_hit);
    sec_tick = 1'b0; ack = 1'b0; snooze = 1'b0;
  endtask

  // Advance the time-of-day by one second, tick, then idle for gap-1 cycles.
  task automatic sec(int gap);
    tod = (tod + 1) % 86400;
    drive_time(tod);
    sec_tick = 1'b1;
    cyc();
    for (int g = 1; g < gap; g++) cyc();
  endtask

  int r, gap, ch, mins;

  initial begin
    rst = 1'b1; sec_tick = 1'b0; chime_en = 1'b0; ack = 1'b0; snooze = 1'b0;
    alarm_time = 32'h0; alarm_en = 2'b00;
    tod = 0; drive_time(tod);
    m_mode = M_IDLE; m_age = 0; m_sec = 0; m_since_load = 0; m_hit = 2'b00;

    // Reset state
    cyc(); cyc();
    chk_bit("rst_buzzer", buzzerOutput, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_vec("rst_hit", alarm_hit, 2'b00);
    rst = 1'b0;

    // Pre-warning beeps and top-of-hour chime
    chime_en = 1'b1;
    tod = 7*3600 + 59*60 + 47; drive_time(tod);
    repeat (3) cyc();
    sec(12); sec(12);                  // 59:48, 59:49
    sec(12 + $urandom_range(0, 8));    // 59:50
    for (int i = 0; i < 10; i++) sec(10 + $urandom_range(0, 12));  // to 00:00
    chk_bit("top_busy_after", busy, 1'b1);
    for (int i = 0; i < 4; i++) sec(8 + $urandom_range(0, 6));

    // Chime disabled: nothing sounds across the hour
    chime_en = 1'b0;
    tod = 8*3600 + 59*60 + 50; drive_time(tod);
    for (int i = 0; i < 10; i++) sec(6 + $urandom_range(0, 6));
    chk_bit("nochime_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) sec(6);

    // Alarm 0 at 07:30, full 60-second episode
    chime_en = 1'b1;
    alarm_time = {bcd16(8, 0), bcd16(7, 30)}; alarm_en = 2'b01;
    tod = 7*3600 + 29*60 + 57; drive_time(tod);
    cyc();
    for (int i = 0; i < 3; i++) sec(3 + $urandom_range(0, 7));
    chk_vec("alarm0_hit", alarm_hit, 2'b01);
    chk_bit("alarm0_busy", busy, 1'b1);
    for (int i = 0; i < 59; i++) sec(3 + $urandom_range(0, 7));
    chk_bit("alarm0_last_sec_busy", busy, 1'b1);
    sec(6);
    chk_bit("alarm0_expired_busy", busy, 0);
    chk_vec("alarm0_expired_hit", alarm_hit, 2'b00);
    for (int i = 0; i < 3; i++) sec(5);

    // Second channel one minute later reloads the episode
    alarm_time = {bcd16(7, 31), bcd16(7, 30)}; alarm_en = 2'b11;
    tod = 7*3600 + 29*60 + 58; drive_time(tod);
    cyc();
    for (int i = 0; i < 62; i++) sec(3 + $urandom_range(0, 3));
    chk_vec("reload_hit", alarm_hit, 2'b11);
    for (int i = 0; i < 59; i++) sec(3 + $urandom_range(0, 3));
    chk_bit("reload_busy", busy, 1'b1);
    sec(5);
    chk_bit("reload_expired_busy", busy, 1'b0);

    // Alarm 1 at 08:00 suppresses the chime, ack 3 cycles in
    alarm_time = {bcd16(8, 0), bcd16(7, 30)}; alarm_en = 2'b10; chime_en = 1'b1;
    tod = 7*3600 + 59*60 + 58; drive_time(tod);
    cyc();
    sec(5); sec(1);
    chk_vec("alarm1_hit", alarm_hit, 2'b10);
    cyc(); cyc(); cyc();
    ack = 1'b1;
    cyc();
    chk_bit("ack_busy", busy, 1'b0);
    chk_bit("ack_buzzer", buzzerOutput, 1'b0);
    for (int i = 0; i < 3; i++) sec(6);

    // Reset in the middle of a pre-beep tone
    alarm_en = 2'b00;
    tod = 10*3600 + 59*60 + 49; drive_time(tod);
    cyc();
    sec(7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_bit("midrst_buzzer", buzzerOutput, 1'b0);
    chk_bit("midrst_busy", busy, 1'b0);
    sec(10);
    chk_bit("after_rst_buzzer", buzzerOutput, 1'b0);

    // Randomized run around hour boundaries and alarm minutes
    chime_en = 1'b1;
    for (int it = 0; it < 450; it++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      tod = $urandom_range(0, 23) * 3600 + 59 * 60 + $urandom_range(40, 59);
      else if (r == 1) tod = $urandom_range(0, 23) * 3600 + $urandom_range(0, 59) * 60 + 57;
      else             tod = (tod + 1) % 86400;
      if ($urandom_range(0, 9) == 0) chime_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 14) == 0) begin
        ch = $urandom_range(0, 1);
        mins = (tod / 60 + $urandom_range(0, 1)) % 1440;
        alarm_time[16*ch +: 16] = bcd16(mins / 60, mins % 60);
        alarm_en = 2'($urandom_range(0, 3));
      end
      drive_time(tod);
      if ($urandom_range(0, 29) == 0) Second_Second = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 39) == 0) Minute_Second = 4'($urandom_range(10, 15));
      ack = ($urandom_range(0, 19) == 0);
      snooze = ($urandom_range(0, 9) == 0);
      sec_tick = 1'b1;
      cyc();
      gap = $urandom_range(1, 12);
      for (int g = 0; g < gap; g++) begin
        ack    = ($urandom_range(0, 24) == 0);
        snooze = ($urandom_range(0, 19) == 0);
        rst    = ($urandom_range(0, 299) == 0);
        cyc();
      end
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
